multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle sequencing FSM for the RISC-V core datapath: instruction fetch, decode, execute, memory access and writeback over several clocks, sharing one memory port between instruction and data access.
- Drives the immediate generator's format select, ALU operand/op selects, memory handshake, register-file write and PC update.
- Counts retired instructions.

Parameters:
- INTRSIZE, 32, instruction width.
- INSTRET_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  start request; sampled only in IDLE.
- instr  in  INTRSIZE  current IR contents; stable from DECODE to end of instruction.
- branch_taken  in  1  comparator result; valid in EXEC.
- mem_ready  in  1  memory accepts/completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = store access.
- addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  update PC this cycle.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- imm_sel  out  2  0 = I, 1 = S, 2 = B, 3 = none.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- alu_op  out  2  0 = add, 1 = sub/compare, 2 = funct-decoded.
- reg_write  out  1  register-file write enable.
- wb_sel  out  1  0 = ALU result, 1 = memory data.
- state_o  out  3  current state encoding.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Opcode classes use the shared defines from defines.vh:
  - R = 0110011
  - I_type = 0010011
  - L_type = 0000011
  - S_type = 0100011
  - B_type = 1100011
  - Any other opcode is illegal.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset (async, rst_n low):
  - State goes to IDLE, instret=0, latched class cleared.
  - Every output is 0 immediately, including mem_req. imm_sel=3 is not the reset value; imm_sel resets to 0.
  - Reset mid-access aborts the access with no handshake completion.
- IDLE: all enables 0. When run=1, go to FETCH.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - mem_req stays high until mem_ready is sampled 1.
  - ir_write = mem_ready (Mealy, same cycle). Then go to DECODE.
- DECODE (exactly 1 cycle):
  - Latch the opcode class from instr[6:0].
  - Drive imm_sel for that class: I/L → 0, S → 1, B → 2, R → 3.
  - imm_sel then holds constant until the next DECODE.
  - Illegal opcode: go to FETCH as a NOP with pc_write=1 and pc_src=0; counted as retired.
- EXEC (1 cycle):
  - R: alu_src_b=0, alu_op=2; go to WB.
  - I: alu_src_b=1, alu_op=2; go to WB.
  - L/S: alu_src_b=1, alu_op=0; go to MEM.
  - B: alu_src_b=0, alu_op=1, pc_write=1, pc_src=branch_taken; go to FETCH.
- MEM:
  - mem_req=1, addr_sel=1; mem_we=1 for S only. Hold until mem_ready.
  - L: go to WB.
  - S: pc_write=1, pc_src=0 in the mem_ready cycle; go to FETCH.
- WB (1 cycle):
  - reg_write=1; wb_sel=1 for L, 0 otherwise.
  - pc_write=1, pc_src=0; go to FETCH.
- Retire and cycle counts:
  - instret increments by 1 in every cycle with pc_write=1, wrapping modulo 2^INSTRET_W.
  - Cycles per instruction with zero-wait memory: R/I/L = 4 (+1 for L's memory), S = 4, B = 3.
- Outputs not listed for a state are 0.
- reg_write and mem_we are never both 1.
- run is ignored outside IDLE; the FSM never returns to IDLE except via reset.

Optional Feature:
- ILLEGAL_TRAP_EN defined:
  - Illegal opcode in DECODE moves to TRAP.
  - TRAP drives all enables 0 and holds until reset; PC is not written and instret does not increment.
  - Adds port illegal (out, 1), which is 1 in TRAP and 0 otherwise.
- Not defined: illegal opcode is a NOP as above, the TRAP state is unreachable, and there is no illegal port.

Test Plan:
- Reset, run=1, mem_ready tied 1, instr=addi x1,x0,5 (0x00500093):
  - states 0→1→2→3→5→1;
  - imm_sel=0 and alu_src_b=1 in EXEC;
  - reg_write=1 in WB;
  - instret=1.
- Load lw x2,4(x0) (0x00402103) with mem_ready low for 3 MEM cycles:
  - mem_req held 4 cycles, addr_sel=1, mem_we=0;
  - WB shows wb_sel=1;
  - total 8 cycles from FETCH.
- Store sw x2,8(x0) (0x00202423):
  - imm_sel=1;
  - MEM shows mem_we=1 and pc_write=1 on the ready cycle;
  - reg_write never 1.
- Branch beq (0x00000463) with branch_taken=1, then again with branch_taken=0:
  - EXEC shows pc_write=1, pc_src=1 then 0;
  - imm_sel=2, alu_op=1;
  - 3 cycles each.
- Assert rst_n=0 mid-MEM with mem_req=1:
  - mem_req drops without waiting for a clock edge;
  - state_o=0, instret=0.
- Illegal opcode 0x0000007F:
  - Without the macro: NOP, pc_write=1, back to FETCH, instret increments.
  - With ILLEGAL_TRAP_EN: state_o=6, illegal=1, no further mem_req.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory port between the multi-cycle controller and memory.
// The controller is the master: it requests and selects the address source; memory answers with mem_ready.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V sequencing FSM: fetch, decode, execute, memory, writeback over one shared memory port.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes park the FSM in TRAP and add the 'illegal' output.
module multicycle_controller #(
    parameter int INTRSIZE  = 32,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [INTRSIZE-1:0]  instr,
    input  logic                 branch_taken,
    multicycle_controller_if.master mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic [1:0]           imm_sel,
    output logic                 alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic                 wb_sel,
    output logic [2:0]           state_o,
    output logic [INSTRET_W-1:0] instret
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                 illegal
`endif
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [INSTRET_W-1:0] INSTRET_ONE = INSTRET_W'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
        MEM = 3'd4, WB = 3'd5, TRAP = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_R, C_I, C_L, C_S, C_B, C_ILL
    } cls_t;

    function automatic cls_t decode_cls(input logic [6:0] op);
        case (op)
            OP_R:    return C_R;
            OP_I:    return C_I;
            OP_L:    return C_L;
            OP_S:    return C_S;
            OP_B:    return C_B;
            default: return C_ILL;
        endcase
    endfunction

    // R-type and illegal opcodes carry no immediate, reported as format 3.
    function automatic logic [1:0] imm_fmt(input cls_t c);
        case (c)
            C_I, C_L: return 2'd0;
            C_S:      return 2'd1;
            C_B:      return 2'd2;
            default:  return 2'd3;
        endcase
    endfunction

    state_t         state_q, state_d;
    cls_t           cls_q, dec_cls;
    logic [1:0]     imm_q;
    logic           unused_instr_hi;

    assign dec_cls         = decode_cls(instr[6:0]);
    assign unused_instr_hi = ^instr[INTRSIZE-1:7];
    assign state_o         = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal         = (state_q == TRAP);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cls_q   <= C_NONE;
            imm_q   <= 2'd0;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                cls_q <= dec_cls;
                imm_q <= imm_fmt(dec_cls);
            end
            if (pc_write) instret <= instret + INSTRET_ONE;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        imm_sel      = imm_q;
        alu_src_b    = 1'b0;
        alu_op       = 2'd0;
        reg_write    = 1'b0;
        wb_sel       = 1'b0;
        case (state_q)
            IDLE: if (run) state_d = FETCH;
            FETCH: begin
                mem.mem_req = 1'b1;
                ir_write    = mem.mem_ready;
                if (mem.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                imm_sel = imm_fmt(dec_cls);
                if (dec_cls == C_ILL) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d  = TRAP;
`else
                    // Illegal opcode retires as a NOP so the program keeps moving.
                    pc_write = 1'b1;
                    state_d  = FETCH;
`endif
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (cls_q)
                    C_R: begin
                        alu_op  = 2'd2;
                        state_d = WB;
                    end
                    C_I: begin
                        alu_src_b = 1'b1;
                        alu_op    = 2'd2;
                        state_d   = WB;
                    end
                    C_L, C_S: begin
                        alu_src_b = 1'b1;
                        state_d   = MEM;
                    end
                    C_B: begin
                        alu_op   = 2'd1;
                        pc_write = 1'b1;
                        pc_src   = branch_taken;
                        state_d  = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                mem.mem_req  = 1'b1;
                mem.addr_sel = 1'b1;
                mem.mem_we   = (cls_q == C_S);
                if (mem.mem_ready) begin
                    if (cls_q == C_S) begin
                        pc_write = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                reg_write = 1'b1;
                wb_sel    = (cls_q == C_L);
                pc_write  = 1'b1;
                state_d   = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven, scoreboarded bench for multicycle_controller; honours ILLEGAL_TRAP_EN when defined.
module tb_multicycle_controller;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h00402103;
    localparam logic [31:0] SW   = 32'h00202423;
    localparam logic [31:0] BEQ  = 32'h00000463;
    localparam logic [31:0] ILL  = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] instr = '0;
    logic        branch_taken = 1'b0;
    logic        ir_write, pc_write, pc_src, alu_src_b, reg_write, wb_sel;
    logic [1:0]  imm_sel, alu_op;
    logic [2:0]  state_o;
    logic [31:0] instret;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    multicycle_controller_if bus ();

    multicycle_controller #(.INTRSIZE(32), .INSTRET_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .branch_taken(branch_taken),
        .mem(bus), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .imm_sel(imm_sel), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .wb_sel(wb_sel), .state_o(state_o), .instret(instret)
`ifdef ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        run;
        logic [31:0] instr;
        logic        bt;
        logic        rdy;
        logic [2:0]  st;
        logic [12:0] ctl;
        logic [31:0] ir;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int total = 0;
    int bad   = 0;

    // Control word order: mem_req mem_we addr_sel ir_write pc_write pc_src imm_sel[1:0] alu_src_b alu_op[1:0] reg_write wb_sel
    function automatic logic [12:0] pk(input logic mreq, input logic mwe, input logic asel,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic [1:0] imm, input logic asb,
                                       input logic [1:0] aop, input logic rw, input logic wbs);
        return {mreq, mwe, asel, irw, pcw, pcs, imm, asb, aop, rw, wbs};
    endfunction

    function automatic logic [12:0] dut_ctl();
        return {bus.mem_req, bus.mem_we, bus.addr_sel, ir_write, pc_write, pc_src,
                imm_sel, alu_src_b, alu_op, reg_write, wb_sel};
    endfunction

    task automatic add(input string n, input logic [31:0] i, input logic b, input logic rd,
                       input logic [2:0] s, input logic [12:0] c, input logic [31:0] ir);
        vec_t v;
        v.name = n; v.run = 1'b1; v.instr = i; v.bt = b; v.rdy = rd;
        v.st = s; v.ctl = c; v.ir = ir;
        tbl.push_back(v);
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        // addi: IDLE -> FETCH -> DECODE -> EXEC -> WB, zero-wait memory
        add("idle",      ADDI, 0, 1, 3'd0, pk(0,0,0,0,0,0,2'd0,0,2'd0,0,0), 0);
        add("a_fetch",   ADDI, 0, 1, 3'd1, pk(1,0,0,1,0,0,2'd0,0,2'd0,0,0), 0);
        add("a_dec",     ADDI, 0, 1, 3'd2, pk(0,0,0,0,0,0,2'd0,0,2'd0,0,0), 0);
        add("a_exec",    ADDI, 0, 1, 3'd3, pk(0,0,0,0,0,0,2'd0,1,2'd2,0,0), 0);
        add("a_wb",      ADDI, 0, 1, 3'd5, pk(0,0,0,0,1,0,2'd0,0,2'd0,1,0), 0);
        // lw with three wait cycles in MEM
        add("l_fetch",   LW,   0, 1, 3'd1, pk(1,0,0,1,0,0,2'd0,0,2'd0,0,0), 1);
        add("l_dec",     LW,   0, 1, 3'd2, pk(0,0,0,0,0,0,2'd0,0,2'd0,0,0), 1);
        add("l_exec",    LW,   0, 1, 3'd3, pk(0,0,0,0,0,0,2'd0,1,2'd0,0,0), 1);
        add("l_mem_w1",  LW,   0, 0, 3'd4, pk(1,0,1,0,0,0,2'd0,0,2'd0,0,0), 1);
        add("l_mem_w2",  LW,   0, 0, 3'd4, pk(1,0,1,0,0,0,2'd0,0,2'd0,0,0), 1);
        add("l_mem_w3",  LW,   0, 0, 3'd4, pk(1,0,1,0,0,0,2'd0,0,2'd0,0,0), 1);
        add("l_mem_rdy", LW,   0, 1, 3'd4, pk(1,0,1,0,0,0,2'd0,0,2'd0,0,0), 1);
        add("l_wb",      LW,   0, 1, 3'd5, pk(0,0,0,0,1,0,2'd0,0,2'd0,1,1), 1);
        // sw with one fetch wait cycle
        add("s_fetch_w", SW,   0, 0, 3'd1, pk(1,0,0,0,0,0,2'd0,0,2'd0,0,0), 2);
        add("s_fetch",   SW,   0, 1, 3'd1, pk(1,0,0,1,0,0,2'd0,0,2'd0,0,0), 2);
        add("s_dec",     SW,   0, 1, 3'd2, pk(0,0,0,0,0,0,2'd1,0,2'd0,0,0), 2);
        add("s_exec",    SW,   0, 1, 3'd3, pk(0,0,0,0,0,0,2'd1,1,2'd0,0,0), 2);
        add("s_mem",     SW,   0, 1, 3'd4, pk(1,1,1,0,1,0,2'd1,0,2'd0,0,0), 2);
        // beq taken, then not taken
        add("b1_fetch",  BEQ,  0, 1, 3'd1, pk(1,0,0,1,0,0,2'd1,0,2'd0,0,0), 3);
        add("b1_dec",    BEQ,  0, 1, 3'd2, pk(0,0,0,0,0,0,2'd2,0,2'd0,0,0), 3);
        add("b1_exec",   BEQ,  1, 1, 3'd3, pk(0,0,0,0,1,1,2'd2,0,2'd1,0,0), 3);
        add("b0_fetch",  BEQ,  0, 1, 3'd1, pk(1,0,0,1,0,0,2'd2,0,2'd0,0,0), 4);
        add("b0_dec",    BEQ,  0, 1, 3'd2, pk(0,0,0,0,0,0,2'd2,0,2'd0,0,0), 4);
        add("b0_exec",   BEQ,  0, 1, 3'd3, pk(0,0,0,0,1,0,2'd2,0,2'd1,0,0), 4);
        // illegal opcode
        add("i_fetch",   ILL,  0, 1, 3'd1, pk(1,0,0,1,0,0,2'd2,0,2'd0,0,0), 5);
`ifdef ILLEGAL_TRAP_EN
        add("i_dec",     ILL,  0, 1, 3'd2, pk(0,0,0,0,0,0,2'd3,0,2'd0,0,0), 5);
        add("i_trap1",   ILL,  0, 1, 3'd6, pk(0,0,0,0,0,0,2'd3,0,2'd0,0,0), 5);
        add("i_trap2",   ILL,  0, 1, 3'd6, pk(0,0,0,0,0,0,2'd3,0,2'd0,0,0), 5);
`else
        add("i_dec",     ILL,  0, 1, 3'd2, pk(0,0,0,0,1,0,2'd3,0,2'd0,0,0), 5);
        add("i_refetch", ILL,  0, 1, 3'd1, pk(1,0,0,1,0,0,2'd3,0,2'd0,0,0), 6);
`endif

        bus.mem_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state",   64'(state_o), 64'(3'd0));
        chk("rst_ctl",     64'(dut_ctl()), 64'(13'd0));
        chk("rst_instret", 64'(instret), 64'(32'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            run           = tbl[k].run;
            instr         = tbl[k].instr;
            branch_taken  = tbl[k].bt;
            bus.mem_ready = tbl[k].rdy;
            sb.push_back(tbl[k]);
            @(negedge clk);
            e = sb.pop_front();
            chk({e.name, "_state"},   64'(state_o),   64'(e.st));
            chk({e.name, "_ctl"},     64'(dut_ctl()), 64'(e.ctl));
            chk({e.name, "_instret"}, 64'(instret),   64'(e.ir));
`ifdef ILLEGAL_TRAP_EN
            chk({e.name, "_illegal"}, 64'(illegal),   64'(e.st == 3'd6));
`endif
            @(posedge clk);
            #1;
        end

        // Async reset between edges clears state, counter and the held immediate format
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state",   64'(state_o), 64'(3'd0));
        chk("arst_imm",     64'(imm_sel), 64'(2'd0));
        chk("arst_instret", 64'(instret), 64'(32'd0));
        chk("arst_ctl",     64'(dut_ctl()), 64'(13'd0));
`ifdef ILLEGAL_TRAP_EN
        chk("arst_illegal", 64'(illegal), 64'(1'b0));
`endif

        // Reset asserted mid-MEM drops mem_req without a clock edge
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run = 1'b1;
        instr = LW;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_pre_state", 64'(state_o), 64'(3'd4));
        chk("abort_pre_req",   64'(bus.mem_req), 64'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_req",     64'(bus.mem_req), 64'(1'b0));
        chk("abort_asel",    64'(bus.addr_sel), 64'(1'b0));
        chk("abort_state",   64'(state_o), 64'(3'd0));
        chk("abort_instret", 64'(instret), 64'(32'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
